// File: rtl/hdmi_line_fetcher_pkg.sv
// Shared types for the HDMI line fetcher: FSM states, RGB565 field layout, colour expansion.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package hdmi_line_fetcher_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREFILL0 = 3'd1,
    ST_PREFILL1 = 3'd2,
    ST_DONE     = 3'd3,
    ST_FILL     = 3'd4
  } fetch_state_t;

  // RGB565 field positions within a 16-bit pixel
  localparam int R_HI = 15;
  localparam int R_LO = 11;
  localparam int G_HI = 10;
  localparam int G_LO = 5;
  localparam int B_HI = 4;
  localparam int B_LO = 0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Widen each field to 8 bits by replicating its top bits into the low end,
  // so full-scale 565 values map to 0xFF.
  function automatic rgb_t rgb565_expand(input logic [15:0] p);
    rgb_t c;
    c.r = {p[R_HI:R_LO], p[R_HI:R_HI-2]};
    c.g = {p[G_HI:G_LO], p[G_HI:G_HI-1]};
    c.b = {p[B_HI:B_LO], p[B_HI:B_HI-2]};
    return c;
  endfunction

endpackage

// File: rtl/hdmi_linebuf_dp.sv
// Two-bank line buffer: one write port (fill side), one read port (display side), bank = address MSB.
// Latency: read data registered, valid one cycle after raddr is presented.
// Backpressure: none; both ports accept an access every cycle.
module hdmi_linebuf_dp #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  // Write port: storage array carries no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port, output register cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/hdmi_line_fetcher.sv
// Ping-pong scanline prefetcher: fills one line bank from memory while the other feeds RGB888 pixels.
// Latency: pixel out one cycle after fetch_next is sampled; one memory word per mem_req/mem_ack handshake.
// Backpressure: mem_req held with stable mem_addr until mem_ack; a late fill is aborted and flagged in underrun.
module hdmi_line_fetcher
  import hdmi_line_fetcher_pkg::*;
#(
  parameter int LINE_PIXELS = 640,
  parameter int LINES       = 480,
  parameter int ADDR_W      = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              next_field,
  input  logic              next_line,
  input  logic              fetch_next,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              underrun
);

  localparam int WORDS  = LINE_PIXELS / 2;
  localparam int IDX_W  = $clog2(WORDS);
  localparam int PTR_W  = $clog2(LINE_PIXELS);
  localparam int LIDX_W = $clog2(LINES + 2);
  localparam logic [ADDR_W-1:0] LINE_STEP  = ADDR_W'(WORDS);
  localparam logic [ADDR_W-1:0] LINE_STEP2 = ADDR_W'(2 * WORDS);

  fetch_state_t      state, state_nxt;
  logic              disp_bank, fill_bank, discard;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LIDX_W-1:0] line_idx;
  logic [IDX_W-1:0]  word_idx;
  logic [ADDR_W-1:0] line_addr, fill_base;
  logic              fill_state, ev_field, ev_line, ack_last, tgt_ok, buf_we;
  logic              fetch_q, half_q;
  logic [31:0]       buf_q;
  logic [15:0]       pix;
  rgb_t              pix_rgb;

  assign ev_field   = enable & next_field;
  // next_field takes priority; line ends before the first field are ignored
  assign ev_line    = enable & next_line & ~next_field & (state != ST_IDLE);
  assign fill_state = (state == ST_PREFILL0) | (state == ST_PREFILL1) | (state == ST_FILL);
  assign buf_we     = fill_state & mem_req & mem_ack & ~discard;
  assign ack_last   = buf_we & (word_idx == IDX_W'(WORDS - 1));
  // Line to fill after a swap is two ahead of the line currently shown
  assign tgt_ok     = ({1'b0, line_idx} + (LIDX_W+1)'(2)) < (LIDX_W+1)'(LINES);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: disable, field restart and line swap override fill progress
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else if (ev_field) begin
      state_nxt = ST_PREFILL0;
    end else if (ev_line) begin
      state_nxt = tgt_ok ? ST_FILL : ST_DONE;
    end else if (ack_last) begin
      state_nxt = (state == ST_PREFILL0) ? ST_PREFILL1 : ST_DONE;
    end
  end

  // Display-side bookkeeping: shown bank, read pointer, current line and its base address
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_bank <= 1'b0;
      rd_ptr    <= '0;
      line_idx  <= '0;
      line_addr <= '0;
    end else if (ev_field) begin
      disp_bank <= 1'b0;
      rd_ptr    <= '0;
      line_idx  <= '0;
      line_addr <= fb_base;
    end else if (ev_line) begin
      disp_bank <= ~disp_bank;
      rd_ptr    <= '0;
      line_addr <= line_addr + LINE_STEP;
      if (line_idx != LIDX_W'(LINES)) begin
        line_idx <= line_idx + 1'b1;
      end
    end else if (enable && fetch_next) begin
      rd_ptr <= (rd_ptr == PTR_W'(LINE_PIXELS - 1)) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Memory request engine: one word in flight; an aborted request is drained before the next fill
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      discard   <= 1'b0;
      word_idx  <= '0;
      fill_base <= '0;
      fill_bank <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (mem_req && mem_ack) begin
        mem_req <= 1'b0;
        discard <= 1'b0;
      end
      if (!enable || ev_field || ev_line) begin
        // Never withdraw an outstanding request; mark its data as stale instead
        if (mem_req && !mem_ack) begin
          discard <= 1'b1;
        end
        word_idx <= '0;
        if (ev_field) begin
          fill_base <= fb_base;
          fill_bank <= 1'b0;
        end
        if (ev_line) begin
          fill_base <= line_addr + LINE_STEP2;
          fill_bank <= disp_bank;
          if (fill_state) begin
            underrun <= 1'b1;
          end
        end
      end else if (fill_state && !discard) begin
        if (mem_req && mem_ack) begin
          if (ack_last) begin
            word_idx <= '0;
            if (state == ST_PREFILL0) begin
              fill_base <= fill_base + LINE_STEP;
              fill_bank <= 1'b1;
            end
          end else begin
            word_idx <= word_idx + 1'b1;
            mem_req  <= 1'b1;
            mem_addr <= fill_base + ADDR_W'(word_idx) + ADDR_W'(1);
          end
        end else if (!mem_req) begin
          mem_req  <= 1'b1;
          mem_addr <= fill_base + ADDR_W'(word_idx);
        end
      end
    end
  end

  hdmi_linebuf_dp #(
    .AW (IDX_W + 1)
  ) u_linebuf (
    .clk   (clk),
    .rst   (rst),
    .we    (buf_we),
    .waddr ({fill_bank, word_idx}),
    .wdata (mem_rdata),
    .raddr ({disp_bank, rd_ptr[PTR_W-1:1]}),
    .rdata (buf_q)
  );

  assign pix     = half_q ? buf_q[31:16] : buf_q[15:0];
  assign pix_rgb = rgb565_expand(pix);

  // Pixel output: track which fetch the RAM output belongs to, then expand it
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_q <= 1'b0;
      half_q  <= 1'b0;
      red     <= '0;
      green   <= '0;
      blue    <= '0;
    end else begin
      fetch_q <= enable & fetch_next;
      half_q  <= rd_ptr[0];
      if (!enable) begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end else if (fetch_q) begin
        red   <= pix_rgb.r;
        green <= pix_rgb.g;
        blue  <= pix_rgb.b;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_line_fetcher.sv
// Directed bench for hdmi_line_fetcher with an auto-acking memory model.
// Latency: memory model acks every other cycle while ack_en is set.
// Backpressure: ack_en=0 withholds mem_ack to force an outstanding request.
module tb_hdmi_line_fetcher;

  logic        clk = 1'b0;
  logic        rst, enable, next_field, next_line, fetch_next;
  logic [23:0] fb_base;
  logic [7:0]  red, green, blue;
  logic        mem_req, mem_ack, underrun;
  logic [23:0] mem_addr;
  logic [31:0] mem_rdata;

  logic        ack_en;
  logic [23:0] ack_log [$];
  logic [23:0] held;
  int          total = 0;
  int          bad   = 0;

  hdmi_line_fetcher dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fb_base    (fb_base),
    .next_field (next_field),
    .next_line  (next_line),
    .fetch_next (fetch_next),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .underrun   (underrun)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [23:0] a);
    if (a == 24'h001000) return 32'hFFFF_F800;
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory responder: one-cycle ack pulse for each granted request
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req && ack_en) begin
        mem_ack   = 1'b1;
        mem_rdata = model(mem_addr);
        ack_log.push_back(mem_addr);
      end
    end
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int c = 0;
    while (ack_log.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(ack_log.size() >= n), 32'd1);
  endtask

  task automatic wait_busy(input string tag);
    int c = 0;
    while (!(mem_req && !mem_ack) && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(mem_req && !mem_ack), 32'd1);
  endtask

  task automatic pulse_field();
    @(negedge clk); next_field = 1'b1;
    @(negedge clk); next_field = 1'b0;
  endtask

  task automatic pulse_line();
    @(negedge clk); next_line = 1'b1;
    @(negedge clk); next_line = 1'b0;
  endtask

  task automatic fetch_one(input string tag, input logic [23:0] exp);
    @(negedge clk); fetch_next = 1'b1;
    @(negedge clk); fetch_next = 1'b0;
    @(negedge clk);
    chk(tag, {8'h0, red, green, blue}, {8'h0, exp});
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; next_field = 1'b0; next_line = 1'b0;
    fetch_next = 1'b0; fb_base = '0; ack_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rgb", {red, green, blue}, 0);
    chk("rst_underrun", underrun, 0);
    rst = 1'b0;

    // 1: prefill of lines 0 and 1 from 0x1000, then idle
    enable = 1'b1; fb_base = 24'h001000;
    ack_log.delete();
    pulse_field();
    wait_log("t1_wait", 640, 4000);
    repeat (20) @(negedge clk);
    chk("t1_count", ack_log.size(), 640);
    chk("t1_idle_req", mem_req, 0);
    for (int i = 0; i < 640 && i < ack_log.size(); i++)
      chk($sformatf("t1_addr%0d", i), ack_log[i], 32'h1000 + i);

    // 2: two fetches from bank 0 word 0 (0xFFFF_F800), one-cycle latency
    @(negedge clk); fetch_next = 1'b1;
    @(negedge clk);
    chk("t2_latency", {red, green, blue}, 24'h000000);
    @(negedge clk); fetch_next = 1'b0;
    chk("t2_pix0", {red, green, blue}, 24'hFF0000);
    @(negedge clk);
    chk("t2_pix1", {red, green, blue}, 24'hFFFFFF);
    @(negedge clk);
    chk("t2_hold", {red, green, blue}, 24'hFFFFFF);

    // 3: line swap -> line 2 fill at 0x1280 into bank 0, display bank 1
    ack_log.delete();
    pulse_line();
    wait_log("t3_wait", 5, 100);
    chk("t3_first", ack_log[0], 32'h1280);
    chk("t3_underrun", underrun, 0);
    fetch_one("t3_bank1_pix", 24'h102800);
    ack_en = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < ack_log.size(); i++)
      chk($sformatf("t3_addr%0d", i), ack_log[i], 32'h1280 + i);
    held = 24'h001280 + 24'(ack_log.size());
    chk("t3_held_req", mem_req, 1);
    chk("t3_held_addr", mem_addr, held);

    // 4: swap while line 2 fill is stalled -> underrun, pending word drained, line 3 at 0x13C0
    pulse_line();
    repeat (3) @(negedge clk);
    chk("t4_underrun", underrun, 1);
    chk("t4_req_kept", mem_req, 1);
    chk("t4_addr_kept", mem_addr, held);
    fetch_one("t4_bank0_pix", 24'h105100);
    ack_log.delete();
    ack_en = 1'b1;
    wait_log("t4_wait", 3, 100);
    chk("t4_drain", ack_log[0], held);
    chk("t4_line3_w0", ack_log[1], 32'h13C0);
    chk("t4_line3_w1", ack_log[2], 32'h13C1);

    // 5: next_field and next_line together mid-fill -> restart at 0x2000, no swap
    wait_busy("t5_busy");
    fb_base = 24'h002000;
    ack_log.delete();
    next_field = 1'b1; next_line = 1'b1;
    @(negedge clk);
    next_field = 1'b0; next_line = 1'b0;
    wait_log("t5_wait", 641, 4000);
    repeat (10) @(negedge clk);
    chk("t5_count", ack_log.size(), 641);
    for (int i = 0; i < 640 && i + 1 < ack_log.size(); i++)
      chk($sformatf("t5_addr%0d", i), ack_log[i+1], 32'h2000 + i);
    chk("t5_underrun_sticky", underrun, 1);
    fetch_one("t5_bank0_pix", 24'h210000);
    ack_log.delete();
    pulse_line();
    wait_log("t5_line_wait", 1, 50);
    chk("t5_line2_addr", ack_log[0], 32'h2280);

    // 6: advance to line 477, then the swap to 478 fills line 479, the swap to 479 fills nothing
    for (int i = 0; i < 476; i++) begin
      pulse_line();
      @(negedge clk);
    end
    wait_busy("t6_busy_a");
    ack_log.delete();
    pulse_line();
    wait_log("t6_wait", 3, 100);
    chk("t6_line479_w0", ack_log[1], 32'h276C0);
    chk("t6_line479_w1", ack_log[2], 32'h276C1);
    wait_busy("t6_busy_b");
    ack_log.delete();
    pulse_line();
    repeat (30) @(negedge clk);
    chk("t6_no_fill480", ack_log.size(), 1);
    chk("t6_idle_req", mem_req, 0);

    // enable=0 with a request outstanding: request held until ack, rgb forced black
    fb_base = 24'h003000;
    pulse_field();
    wait_log("t6_en_wait", 2, 50);
    ack_en = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_dis_req_kept", mem_req, 1);
    chk("t6_dis_rgb", {red, green, blue}, 24'h000000);
    ack_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_dis_req_drop", mem_req, 0);
    pulse_field();
    repeat (10) @(negedge clk);
    chk("t6_dis_field_ignored", mem_req, 0);
    fetch_one("t6_dis_fetch_black", 24'h000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
